// File: rtl/cr16_seq_gen_fsm.sv
// ---------------------------------------------------------------------------
// cr16_seq_gen_fsm
//
// Purpose:
//   Sequence-generator controller for the CR16 datapath. It drives the
//   datapath control inputs so that registers r0..r(NUM_REGS-1) are filled
//   with one of three run-time selectable sequences:
//     - Fibonacci  (I_MODE = 00 or 11): r[k] = r[k-1] + r[k-2]
//     - doubling   (I_MODE = 01)      : r[k] = r[k-1] + r[k-1]
//     - arithmetic (I_MODE = 10)      : r[k] = r[k-1] + (seed1 - seed0)
//   An internal reference model tracks the expected value of every term and
//   compares it against the datapath write port on each write cycle. The
//   first failing term index is captured and a sticky flag is raised.
//
// Ports:
//   I_CLK, I_RESET        clock, synchronous active-high reset
//   I_START               start pulse, honoured only in IDLE and DONE
//   I_MODE                sequence mode
//   I_SEED0, I_SEED1      values for r0 and r1
//   I_WRITE_PORT          combinational ALU result from the datapath
//   I_STEP                single-step advance (only with the macro below)
//   O_REG_ENABLE          one-hot register write enable
//   O_READ_A_SEL/B_SEL    datapath read-port selects
//   O_IMMEDIATE, O_IMM_SEL immediate operand and its operand-B select
//   O_OPCODE              ALU opcode (1 = unsigned add while writing)
//   O_DP_NRESET           active-low datapath register-file reset
//   O_BUSY, O_DONE        run status
//   O_MISMATCH            sticky compare-failure flag
//   O_FAIL_INDEX          term index of the first compare failure
//
// Configuration:
//   CR16_SEQ_SINGLE_STEP_EN  when defined, adds I_STEP; CLEAR, SEED0, SEED1
//                            and RUN then wait for I_STEP=1 before each
//                            advance. When undefined the FSM advances every
//                            clock.
// ---------------------------------------------------------------------------
module cr16_seq_gen_fsm #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic                  I_START,
    input  logic [1:0]            I_MODE,
    input  logic [DATA_WIDTH-1:0] I_SEED0,
    input  logic [DATA_WIDTH-1:0] I_SEED1,
    input  logic [DATA_WIDTH-1:0] I_WRITE_PORT,
`ifdef CR16_SEQ_SINGLE_STEP_EN
    input  logic                  I_STEP,
`endif
    output logic [15:0]           O_REG_ENABLE,
    output logic [SEL_WIDTH-1:0]  O_READ_A_SEL,
    output logic [SEL_WIDTH-1:0]  O_READ_B_SEL,
    output logic [DATA_WIDTH-1:0] O_IMMEDIATE,
    output logic                  O_IMM_SEL,
    output logic [3:0]            O_OPCODE,
    output logic                  O_DP_NRESET,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_MISMATCH,
    output logic [SEL_WIDTH-1:0]  O_FAIL_INDEX
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_SEED0 = 3'd2;
    localparam logic [2:0] ST_SEED1 = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] MODE_DOUBLE = 2'b01;
    localparam logic [1:0] MODE_ARITH  = 2'b10;

    localparam logic [SEL_WIDTH-1:0] SEL_ONE    = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_TWO    = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] LAST_INDEX = SEL_WIDTH'(NUM_REGS - 1);

    localparam logic [3:0] OP_ADD = 4'd1;

    logic [2:0]            state_q, state_d;
    logic [SEL_WIDTH-1:0]  index_q, index_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed0_q, seed0_d;
    logic [DATA_WIDTH-1:0] seed1_q, seed1_d;
    logic [DATA_WIDTH-1:0] delta_q, delta_d;
    logic [DATA_WIDTH-1:0] p1_q, p1_d;
    logic [DATA_WIDTH-1:0] p2_q, p2_d;
    logic                  mismatch_q, mismatch_d;
    logic [SEL_WIDTH-1:0]  fail_index_q, fail_index_d;

    logic                  advance;
    logic [DATA_WIDTH-1:0] exp_val;

`ifdef CR16_SEQ_SINGLE_STEP_EN
    assign advance = I_STEP;
`else
    assign advance = 1'b1;
`endif

    // Expected value of the term being written this cycle. The index
    // register doubles as the term index (0 in SEED0, 1 in SEED1), so the
    // same value is captured as the fail index in every write state.
    always_comb begin
        exp_val = '0;
        case (state_q)
            ST_SEED0: exp_val = seed0_q;
            ST_SEED1: exp_val = seed1_q;
            ST_RUN: begin
                case (mode_q)
                    MODE_DOUBLE: exp_val = p1_q + p1_q;
                    MODE_ARITH:  exp_val = p1_q + delta_q;
                    default:     exp_val = p1_q + p2_q;
                endcase
            end
            default: exp_val = '0;
        endcase
    end

    // Next-state, model and compare logic. A START in IDLE or DONE latches
    // the run configuration and clears the sticky compare result; every
    // advancing write cycle shifts the model history and checks the port.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        mode_d       = mode_q;
        seed0_d      = seed0_q;
        seed1_d      = seed1_q;
        delta_d      = delta_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        mismatch_d   = mismatch_q;
        fail_index_d = fail_index_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (I_START) begin
                    mode_d       = I_MODE;
                    seed0_d      = I_SEED0;
                    seed1_d      = I_SEED1;
                    delta_d      = I_SEED1 - I_SEED0;
                    index_d      = '0;
                    mismatch_d   = 1'b0;
                    fail_index_d = '0;
                    state_d      = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (advance) begin
                    state_d = ST_SEED0;
                end
            end
            ST_SEED0, ST_SEED1, ST_RUN: begin
                if (advance) begin
                    p2_d = p1_q;
                    p1_d = exp_val;
                    if (I_WRITE_PORT != exp_val) begin
                        mismatch_d = 1'b1;
                        if (!mismatch_q) begin
                            fail_index_d = index_q;
                        end
                    end
                    if (state_q == ST_SEED0) begin
                        index_d = SEL_ONE;
                        state_d = ST_SEED1;
                    end else if (state_q == ST_SEED1) begin
                        index_d = SEL_TWO;
                        state_d = ST_RUN;
                    end else if (index_q == LAST_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + SEL_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and model registers; reset returns to IDLE from anywhere.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            mode_q       <= '0;
            seed0_q      <= '0;
            seed1_q      <= '0;
            delta_q      <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            mismatch_q   <= 1'b0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            mode_q       <= mode_d;
            seed0_q      <= seed0_d;
            seed1_q      <= seed1_d;
            delta_q      <= delta_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            mismatch_q   <= mismatch_d;
            fail_index_q <= fail_index_d;
        end
    end

    // Datapath control decode. In SEED0/SEED1 port A reads a register that
    // CLEAR has just zeroed, so the ALU passes the immediate straight through.
    always_comb begin
        O_REG_ENABLE = '0;
        O_READ_A_SEL = '0;
        O_READ_B_SEL = '0;
        O_IMMEDIATE  = '0;
        O_IMM_SEL    = 1'b0;
        O_OPCODE     = '0;
        O_DP_NRESET  = 1'b1;
        O_BUSY       = 1'b0;
        O_DONE       = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                O_DP_NRESET = 1'b0;
                O_BUSY      = 1'b1;
            end
            ST_SEED0: begin
                O_REG_ENABLE = 16'h0001;
                O_IMM_SEL    = 1'b1;
                O_IMMEDIATE  = seed0_q;
                O_OPCODE     = OP_ADD;
                O_BUSY       = 1'b1;
            end
            ST_SEED1: begin
                O_REG_ENABLE = 16'h0002;
                O_READ_A_SEL = SEL_ONE;
                O_IMM_SEL    = 1'b1;
                O_IMMEDIATE  = seed1_q;
                O_OPCODE     = OP_ADD;
                O_BUSY       = 1'b1;
            end
            ST_RUN: begin
                O_REG_ENABLE = 16'h0001 << index_q;
                O_READ_A_SEL = index_q - SEL_ONE;
                O_OPCODE     = OP_ADD;
                O_BUSY       = 1'b1;
                case (mode_q)
                    MODE_DOUBLE: O_READ_B_SEL = index_q - SEL_ONE;
                    MODE_ARITH: begin
                        O_IMM_SEL   = 1'b1;
                        O_IMMEDIATE = delta_q;
                    end
                    default:     O_READ_B_SEL = index_q - SEL_TWO;
                endcase
            end
            ST_DONE: O_DONE = 1'b1;
            default: O_DONE = 1'b0;
        endcase
    end

    assign O_MISMATCH   = mismatch_q;
    assign O_FAIL_INDEX = fail_index_q;

endmodule

// File: tb/tb_cr16_seq_gen_fsm.sv
// ---------------------------------------------------------------------------
// tb_cr16_seq_gen_fsm
//
// Drives cr16_seq_gen_fsm against a small behavioural register-file/ALU
// model standing in for cr16_datapath. Expected register contents come from
// a recurrence evaluated over a plain array, independent of the FSM's
// structure. Faults are injected by flipping bit 0 of the write port on
// selected terms.
// ---------------------------------------------------------------------------
module tb_cr16_seq_gen_fsm;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] seed0;
    logic [DW-1:0] seed1;
    logic [DW-1:0] write_port;
`ifdef CR16_SEQ_SINGLE_STEP_EN
    logic          step_in = 1'b1;
`endif

    logic [15:0]   reg_enable;
    logic [SW-1:0] read_a_sel;
    logic [SW-1:0] read_b_sel;
    logic [DW-1:0] immediate;
    logic          imm_sel;
    logic [3:0]    opcode;
    logic          dp_nreset;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [SW-1:0] fail_index;

    int checks = 0;
    int errors = 0;

    // Datapath stand-in
    logic [DW-1:0] rf [N];
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu;
    logic [15:0]   corrupt_mask;

    // Reference sequence
    logic [DW-1:0] model_seq [N];

    always #5 clk = ~clk;

    cr16_seq_gen_fsm #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (N),
        .SEL_WIDTH  (SW)
    ) dut (
        .I_CLK        (clk),
        .I_RESET      (reset),
        .I_START      (start),
        .I_MODE       (mode),
        .I_SEED0      (seed0),
        .I_SEED1      (seed1),
        .I_WRITE_PORT (write_port),
`ifdef CR16_SEQ_SINGLE_STEP_EN
        .I_STEP       (step_in),
`endif
        .O_REG_ENABLE (reg_enable),
        .O_READ_A_SEL (read_a_sel),
        .O_READ_B_SEL (read_b_sel),
        .O_IMMEDIATE  (immediate),
        .O_IMM_SEL    (imm_sel),
        .O_OPCODE     (opcode),
        .O_DP_NRESET  (dp_nreset),
        .O_BUSY       (busy),
        .O_DONE       (done),
        .O_MISMATCH   (mismatch),
        .O_FAIL_INDEX (fail_index)
    );

    // Register file with synchronous clear, written through the one-hot enable
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!dp_nreset)
                rf[k] <= '0;
            else if (reg_enable[k])
                rf[k] <= write_port;
        end
    end

    // Combinational ALU: A + (imm or B) when adding, with optional fault
    always_comb begin
        op_b       = imm_sel ? immediate : rf[read_b_sel];
        alu        = (opcode == 4'd1) ? rf[read_a_sel] + op_b : '0;
        write_port = alu ^ (((reg_enable & corrupt_mask) != 16'h0) ? 16'h0001 : 16'h0000);
    end

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic build_model(input logic [1:0] m, input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        logic [DW-1:0] d;
        d = s1 - s0;
        model_seq[0] = s0;
        model_seq[1] = s1;
        for (int k = 2; k < N; k++) begin
            case (m)
                2'b01:   model_seq[k] = DW'(model_seq[k-1] * 2);
                2'b10:   model_seq[k] = model_seq[k-1] + d;
                default: model_seq[k] = model_seq[k-1] + model_seq[k-2];
            endcase
        end
    endtask

    // Full run from IDLE or DONE, with timing, write order, flags and
    // register contents checked.
    task automatic run_sequence(input logic [1:0] m, input logic [DW-1:0] s0,
                                input logic [DW-1:0] s1, input logic [15:0] cmask,
                                input bit mid_start, input string tag);
        int            cycle;
        int            busy_cnt;
        int            wr_idx;
        logic          exp_mm;
        logic [SW-1:0] exp_fi;
        logic [DW-1:0] last_val;

        build_model(m, s0, s1);
        corrupt_mask = cmask;
        mode  = m;
        seed0 = s0;
        seed1 = s1;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        mode  = ~m;
        seed0 = DW'($urandom);
        seed1 = DW'($urandom);
        cycle    = 1;
        busy_cnt = 0;
        wr_idx   = 0;

        checks++;
        if ({busy, dp_nreset, mismatch, fail_index} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL %s clear_cycle: got busy/nrst/mm/fi=%b expected 1000000", tag,
                     {busy, dp_nreset, mismatch, fail_index});
        end

        while (!done && cycle < 40) begin
            if (busy) busy_cnt++;
            checks++;
            if (reg_enable != 16'h0) begin
                if (reg_enable !== (16'h0001 << wr_idx) || opcode !== 4'd1) begin
                    errors++;
                    $display("[TB] FAIL %s write_order: got en=%h op=%0d expected en=%h op=1", tag,
                             reg_enable, opcode, 16'h0001 << wr_idx);
                end
                wr_idx++;
            end else if (opcode !== 4'd0) begin
                errors++;
                $display("[TB] FAIL %s idle_opcode: got %0d expected 0", tag, opcode);
            end
            start = (mid_start && cycle == 7) ? 1'b1 : 1'b0;
            step_clk();
            cycle++;
        end
        start = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s done_timeout: got done=0 after %0d cycles expected done=1", tag, cycle);
        end
        checks++;
        if (cycle != N + 2) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got %0d expected %0d", tag, cycle, N + 2);
        end
        checks++;
        if (busy_cnt != N + 1) begin
            errors++;
            $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, N + 1);
        end
        checks++;
        if (wr_idx != N) begin
            errors++;
            $display("[TB] FAIL %s write_count: got %0d expected %0d", tag, wr_idx, N);
        end

        exp_mm = (cmask != 16'h0);
        exp_fi = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cmask[k]) exp_fi = SW'(k);
        end
        checks++;
        if (mismatch !== exp_mm || fail_index !== exp_fi) begin
            errors++;
            $display("[TB] FAIL %s compare_flags: got mm=%b fi=%0d expected mm=%b fi=%0d", tag,
                     mismatch, fail_index, exp_mm, exp_fi);
        end

        if (cmask == 16'h0) begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (rf[k] !== model_seq[k]) begin
                    errors++;
                    $display("[TB] FAIL %s r%0d: got %h expected %h", tag, k, rf[k], model_seq[k]);
                end
            end
        end

        last_val = rf[N-1];
        step_clk();
        step_clk();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || reg_enable !== 16'h0 || rf[N-1] !== last_val) begin
            errors++;
            $display("[TB] FAIL %s done_hold: got done=%b busy=%b en=%h r_last=%h expected 1 0 0000 %h",
                     tag, done, busy, reg_enable, rf[N-1], last_val);
        end
        corrupt_mask = 16'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step_clk();
        step_clk();
        reset = 1'b0;
        step_clk();
        checks++;
        if (reg_enable !== 16'h0 || read_a_sel !== '0 || read_b_sel !== '0) begin
            errors++;
            $display("[TB] FAIL reset_selects: got en=%h a=%0d b=%0d expected 0 0 0", reg_enable, read_a_sel, read_b_sel);
        end
        checks++;
        if (immediate !== '0 || imm_sel !== 1'b0 || opcode !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_operands: got imm=%h isel=%b op=%0d expected 0 0 0", immediate, imm_sel, opcode);
        end
        checks++;
        if ({dp_nreset, busy, done, mismatch, fail_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected 10000000", {dp_nreset, busy, done, mismatch, fail_index});
        end
    endtask

    task automatic test_fibonacci;
        run_sequence(2'b00, 16'd1, 16'd1, 16'h0, 1'b0, "fib_1_1");
        checks++;
        if (rf[7] !== 16'd21) begin
            errors++;
            $display("[TB] FAIL fib_r7: got %0d expected 21", rf[7]);
        end
        checks++;
        if (rf[15] !== 16'd987) begin
            errors++;
            $display("[TB] FAIL fib_r15: got %0d expected 987", rf[15]);
        end
    endtask

    task automatic test_doubling;
        run_sequence(2'b01, 16'd3, 16'd3, 16'h0, 1'b0, "dbl_3_3");
        checks++;
        if (rf[15] !== 16'd49152) begin
            errors++;
            $display("[TB] FAIL dbl_r15: got %0d expected 49152", rf[15]);
        end
        run_sequence(2'b01, 16'h8000, 16'h8000, 16'h0, 1'b0, "dbl_wrap");
        checks++;
        if (rf[2] !== 16'h0000 || mismatch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbl_wrap_r2: got r2=%h mm=%b expected 0000 0", rf[2], mismatch);
        end
    endtask

    task automatic test_arithmetic;
        run_sequence(2'b10, 16'd5, 16'd7, 16'h0, 1'b0, "arith_5_7");
        checks++;
        if (rf[7] !== 16'd19) begin
            errors++;
            $display("[TB] FAIL arith_r7: got %0d expected 19", rf[7]);
        end
        run_sequence(2'b10, 16'd7, 16'd5, 16'h0, 1'b0, "arith_7_5");
        checks++;
        if (rf[3] !== 16'd1 || rf[2] !== 16'd3) begin
            errors++;
            $display("[TB] FAIL arith_neg_delta: got r2=%0d r3=%0d expected 3 1", rf[2], rf[3]);
        end
    endtask

    task automatic test_mismatch;
        run_sequence(2'b00, 16'd1, 16'd1, 16'h0050, 1'b0, "fault_4_6");
        checks++;
        if (mismatch !== 1'b1 || fail_index !== 4'd4) begin
            errors++;
            $display("[TB] FAIL fault_sticky: got mm=%b fi=%0d expected 1 4", mismatch, fail_index);
        end
    endtask

    // Restart straight from DONE (flags must clear) with the alias mode 11
    task automatic test_back_to_back;
        run_sequence(2'b11, 16'd2, 16'd5, 16'h0, 1'b0, "b2b_mode3");
        checks++;
        if (rf[4] !== 16'd19) begin
            errors++;
            $display("[TB] FAIL b2b_r4: got %0d expected 19", rf[4]);
        end
    endtask

    task automatic test_start_ignored;
        run_sequence(2'b00, 16'd1, 16'd1, 16'h0, 1'b1, "start_midrun");
    endtask

    task automatic test_reset_mid_run;
        int guard;
        corrupt_mask = 16'h0008;
        mode  = 2'b00;
        seed0 = 16'd1;
        seed1 = 16'd1;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        guard = 0;
        while (!reg_enable[5] && guard < 30) begin
            step_clk();
            guard++;
        end
        checks++;
        if (!reg_enable[5] || mismatch !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_reach: got en=%h mm=%b expected bit5 set mm=1", reg_enable, mismatch);
        end
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        corrupt_mask = 16'h0;
        checks++;
        if ({reg_enable, read_a_sel, read_b_sel, immediate, imm_sel, opcode} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_mid_controls: got en=%h a=%0d b=%0d imm=%h isel=%b op=%0d expected all 0",
                     reg_enable, read_a_sel, read_b_sel, immediate, imm_sel, opcode);
        end
        checks++;
        if ({dp_nreset, busy, done, mismatch, fail_index} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL rst_mid_status: got %b expected 10000000", {dp_nreset, busy, done, mismatch, fail_index});
        end
        step_clk();
        step_clk();
        checks++;
        if (busy !== 1'b0 || reg_enable !== 16'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_stays_idle: got busy=%b en=%h expected 0 0000", busy, reg_enable);
        end
    endtask

    task automatic test_random;
        logic [1:0]  m;
        logic [15:0] mask;
        for (int r = 0; r < 8; r++) begin
            m    = 2'($urandom_range(0, 3));
            mask = (r == 7) ? (16'h0001 << $urandom_range(0, N - 1)) : 16'h0;
            run_sequence(m, DW'($urandom), DW'($urandom), mask, 1'b0, "random");
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        mode         = 2'b00;
        seed0        = '0;
        seed1        = '0;
        corrupt_mask = 16'h0;
        test_reset();
        test_fibonacci();
        test_doubling();
        test_arithmetic();
        test_mismatch();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
